// File: rtl/sp_sram_arb_pkg.sv
// rtl/sp_sram_arb_pkg.sv - shared constants for the single-port SRAM arbiter
package sp_sram_arb_pkg;

  localparam int NREQ = 2;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/sp_sram_arb_rr_arb2.sv
// rtl/sp_sram_arb_rr_arb2.sv - two-way round-robin grant, purely combinational
module rr_arb2
  import sp_sram_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            last,
  input  logic            en,
  output logic [NREQ-1:0] grant
);

  // On contention the requester that did not win last time is served.
  always_comb begin
    grant = '0;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

endmodule

// File: rtl/sp_sram_arb.sv
// rtl/sp_sram_arb.sv - round-robin arbiter and init sequencer for one single-port SRAM
module sp_sram_arb
  import sp_sram_arb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DEPTH      = 2**ADDR_WIDTH,
  parameter int                    INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0]            req_wr,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
  output logic                       rsp_valid,
  output logic                       rsp_id,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       init_done,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_din,
  output logic                       mem_wr,
  input  logic [DATA_WIDTH-1:0]      mem_qout
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [0:0]            ST_RESET  = (INIT_EN != 0) ? ST_INIT : ST_RUN;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  rr_last_q, rr_last_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_id_q, rsp_id_d;

  logic [NREQ-1:0] grant;
  logic            arb_en;
  logic            handshake;
  logic            win_id;

  // Grants are suppressed while rst is high so req_ready reads 0 in reset.
  assign arb_en = (state_q == ST_RUN) && !rst;

  rr_arb2 u_arb (
    .req   (req_valid),
    .last  (rr_last_q),
    .en    (arb_en),
    .grant (grant)
  );

  assign handshake = |(req_valid & grant);
  assign win_id    = grant[1];

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rr_last_d   = rr_last_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_din     = '0;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem_wr     = 1'b1;
        mem_addr   = init_cnt_q;
        mem_din    = INIT_VAL;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_ADDR) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end
      end else begin
        // Without a handshake win_id is 0, so requester 0 fields show through.
        if (win_id) begin
          mem_addr = req_addr[ADDR_WIDTH +: ADDR_WIDTH];
          mem_din  = req_wdata[DATA_WIDTH +: DATA_WIDTH];
        end else begin
          mem_addr = req_addr[0 +: ADDR_WIDTH];
          mem_din  = req_wdata[0 +: DATA_WIDTH];
        end
        mem_wr = handshake & req_wr[win_id];
        if (handshake) begin
          rr_last_d = win_id;
          if (!req_wr[win_id]) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = win_id;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RESET;
      init_cnt_q  <= '0;
      rr_last_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_last_q   <= rr_last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_rdata = mem_qout;
  assign init_done = (state_q == ST_RUN);

endmodule

// File: tb/tb_sp_sram_arb.sv
// tb/tb_sp_sram_arb.sv - scoreboard bench for sp_sram_arb
module tb_sp_sram_arb;

  localparam int AW = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      req_valid, req_ready, req_wr;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic            rsp_valid, rsp_id, init_done, mem_wr;
  logic [DW-1:0]   rsp_rdata, mem_din, mem_qout;
  logic [AW-1:0]   mem_addr;

  logic            b_rst;
  logic [1:0]      b_req_valid, b_req_ready, b_req_wr;
  logic [2*AW-1:0] b_req_addr;
  logic [2*DW-1:0] b_req_wdata;
  logic            b_rsp_valid, b_rsp_id, b_init_done, b_mem_wr;
  logic [DW-1:0]   b_rsp_rdata, b_mem_din, b_mem_qout;
  logic [AW-1:0]   b_mem_addr;

  sp_sram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .INIT_EN(1),
                .INIT_VAL(16'hA5A5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .init_done(init_done), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_wr(mem_wr), .mem_qout(mem_qout)
  );

  sp_sram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .INIT_EN(0),
                .INIT_VAL(16'h0000)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_wr(b_req_wr), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_rdata(b_rsp_rdata),
    .init_done(b_init_done), .mem_addr(b_mem_addr), .mem_din(b_mem_din),
    .mem_wr(b_mem_wr), .mem_qout(b_mem_qout)
  );

  // SRAM macro stand-in: registered read, output unknown after a write.
  logic [DW-1:0] sram [16];
  always @(posedge clk) begin
    if (mem_wr) begin
      sram[mem_addr] <= mem_din;
      mem_qout       <= 'x;
    end else begin
      mem_qout <= sram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            at;
  } exp_t;

  exp_t exp_q[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rsp_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid=%b id=%b data=%h, required no response (cycle %0d)",
                 rsp_valid, rsp_id, rsp_rdata, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
        chk("rsp_cycle", cyc, e.at);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int id, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic exp_rsp, input logic [DW-1:0] exp_data);
    req_valid     = 2'b00;
    req_valid[id] = 1'b1;
    req_wr[id]    = wr;
    req_addr[id*AW +: AW]  = addr;
    req_wdata[id*DW +: DW] = wd;
    @(negedge clk);
    chk("issue_grant", 32'(req_ready), 32'(2'b01 << id));
    chk("issue_mem_wr", 32'(mem_wr), 32'(wr));
    chk("issue_mem_addr", 32'(mem_addr), 32'(addr));
    if (wr) chk("issue_mem_din", 32'(mem_din), 32'(wd));
    if (!wr && exp_rsp) exp_q.push_back('{logic'(id), exp_data, cyc + 1});
    step();
    req_valid = 2'b00;
  endtask

  task automatic check_sweep(input logic with_b);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("sweep_wr", 32'(mem_wr), 1);
      chk("sweep_addr", 32'(mem_addr), i);
      chk("sweep_din", 32'(mem_din), 32'h0000A5A5);
      chk("sweep_ready", 32'(req_ready), 0);
      chk("sweep_done", 32'(init_done), 0);
      if (with_b && i == 0) begin
        chk("b_init_done", 32'(b_init_done), 1);
        chk("b_ready", 32'(b_req_ready), 32'h1);
        chk("b_mem_wr", 32'(b_mem_wr), 1);
        chk("b_mem_addr", 32'(b_mem_addr), 5);
        chk("b_mem_din", 32'(b_mem_din), 32'h000000C3);
        b_req_valid = 2'b00;
      end
      if (with_b && i == 1) chk("b_no_rsp_after_wr", 32'(b_rsp_valid), 0);
      if (i == 15) req_valid = 2'b00;
      step();
    end
    @(negedge clk);
    chk("post_sweep_done", 32'(init_done), 1);
    chk("post_sweep_wr", 32'(mem_wr), 0);
    chk("post_sweep_ready", 32'(req_ready), 0);
    step();
  endtask

  logic [AW-1:0] r1_addr [4] = '{4'd9, 4'd7, 4'd3, 4'd9};
  logic [DW-1:0] r1_data [4] = '{16'hBEEF, 16'hA5A5, 16'h1234, 16'hBEEF};

  initial begin
    rst = 1'b1;  req_valid = 2'b00;  req_wr = 2'b00;  req_addr = '0;  req_wdata = '0;
    b_rst = 1'b1;  b_req_valid = 2'b01;  b_req_wr = 2'b01;
    b_req_addr = {4'd0, 4'd5};  b_req_wdata = {16'h0000, 16'h00C3};
    b_mem_qout = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_din", 32'(mem_din), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("b_rst_init_done", 32'(b_init_done), 1);
    chk("b_rst_ready", 32'(b_req_ready), 0);
    chk("b_rst_mem_wr", 32'(b_mem_wr), 0);

    step();
    rst = 1'b0;  b_rst = 1'b0;  req_valid = 2'b11;
    check_sweep(1'b1);

    issue(0, 1'b0, 4'd7, 16'h0, 1'b1, 16'hA5A5);
    issue(0, 1'b1, 4'd3, 16'h1234, 1'b0, 16'h0);
    issue(1, 1'b0, 4'd3, 16'h0, 1'b1, 16'h1234);
    issue(1, 1'b1, 4'd9, 16'hBEEF, 1'b0, 16'h0);

    // Contention: last winner was 1, so 0 goes first and they alternate.
    req_wr = 2'b00;  req_addr = {4'd9, 4'd3};  req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("alt_grant", 32'(req_ready), (i % 2) ? 32'h2 : 32'h1);
      exp_q.push_back('{logic'(i % 2), (i % 2) ? 16'hBEEF : 16'h1234, cyc + 1});
      step();
    end

    req_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      req_addr[AW +: AW] = r1_addr[i];
      @(negedge clk);
      chk("solo1_grant", 32'(req_ready), 32'h2);
      exp_q.push_back('{1'b1, r1_data[i], cyc + 1});
      step();
    end
    req_addr = {4'd9, 4'd0};  req_valid = 2'b11;
    @(negedge clk);
    chk("after_solo_grant", 32'(req_ready), 32'h1);
    exp_q.push_back('{1'b0, 16'hA5A5, cyc + 1});
    step();
    req_valid = 2'b00;
    repeat (2) step();
    @(negedge clk);
    chk("drain1", exp_q.size(), 0);
    step();

    // Reset right after a read handshake drops the response.
    issue(0, 1'b0, 4'd3, 16'h0, 1'b0, 16'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_mem_wr", 32'(mem_wr), 0);
    step();
    rst = 1'b0;
    check_sweep(1'b0);
    issue(0, 1'b0, 4'd3, 16'h0, 1'b1, 16'hA5A5);
    repeat (2) step();
    @(negedge clk);
    chk("drain2", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1);
  end

endmodule

// File: doc/sp_sram_arb.md
Name: sp_sram_arb

Overview:
- Two-requester round-robin arbiter and sequencer for one single-port SRAM in the FPU datapath (e.g. operand-fetch unit vs. writeback/DMA port).
- After reset, runs an initialisation sweep that writes INIT_VAL to every location, then serves valid/ready requests.
- Returns read data with a fixed 1-cycle latency, tagged with the requester id.
- The SRAM macro is instantiated by the parent and wired to the mem_* ports.

Parameters:
- ADDR_WIDTH, 4, SRAM address width.
- DATA_WIDTH, 16, SRAM word width.
- DEPTH, 2**ADDR_WIDTH, number of words cleared by the init sweep.
- INIT_EN, 1, 1 = run the init sweep after reset; 0 = go straight to RUN.
- INIT_VAL, 0, word written to every location during the sweep.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester accept; a handshake on i occurs when req_valid[i] & req_ready[i].
- req_wr  in  2  per-requester write (1) / read (0).
- req_addr  in  2*ADDR_WIDTH  requester i address in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  2*DATA_WIDTH  requester i write data, packed the same way.
- rsp_valid  out  1  read data valid, one cycle per read; no backpressure.
- rsp_id  out  1  requester that issued the read returned this cycle.
- rsp_rdata  out  DATA_WIDTH  read data; equals mem_qout.
- init_done  out  1  high once the block is in RUN.
- mem_addr  out  ADDR_WIDTH  SRAM address.
- mem_din  out  DATA_WIDTH  SRAM write data.
- mem_wr  out  1  SRAM write enable.
- mem_qout  in  DATA_WIDTH  SRAM registered read data, valid the cycle after a read.

Behaviour:
- States: INIT, RUN.
- Reset entry: rst sends the block to INIT if INIT_EN = 1, else to RUN. Reset also sets init_cnt = 0, rr_last = 1 (requester 0 wins the first contest), and rsp_valid = 0, rsp_id = 0.
- Reset values of the other outputs:
  - init_done = 0 when INIT_EN = 1, else 1.
  - req_ready = 0.
  - mem_wr = 0 (forced low combinationally while rst is high).
  - mem_addr = 0, mem_din = 0.
- INIT state:
  - Each cycle: mem_wr = 1, mem_addr = init_cnt, mem_din = INIT_VAL; init_cnt increments.
  - When init_cnt = DEPTH-1 is written, go to RUN. The sweep takes exactly DEPTH cycles.
  - req_ready = 0 throughout the sweep.
- RUN state, arbitration (combinational, on the current req_valid):
  - If only one requester is valid, it is granted.
  - If both are valid, the requester other than rr_last is granted.
  - req_ready = one-hot grant; at most one bit high.
  - A request with req_valid low is never granted.
- Issue (combinational from the winner):
  - mem_addr and mem_din come from the winner's fields.
  - mem_wr = winner's req_wr & handshake.
  - With no handshake: mem_wr = 0; mem_addr/mem_din hold the requester 0 fields (don't-care).
- rr_last update: set to the winner on every handshake; unchanged otherwise.
- Read response:
  - A read handshake at edge N sets rsp_valid = 1 and rsp_id = winner from edge N until edge N+1.
  - rsp_rdata = mem_qout is valid in that same cycle.
  - Back-to-back reads give back-to-back responses: 1 read/cycle throughput.
- Write response: writes complete at the handshake and produce no response. The cycle after a write has rsp_valid = 0, and mem_qout is X there and must be ignored.
- Mid-operation reset: an in-flight read response is dropped (rsp_valid cleared asynchronously) and the sweep restarts from address 0.
- Port input stability: requesters hold req_* stable while valid and not ready; the arbiter does not register requests.

Decomposition:
- Package sp_sram_arb_pkg:
  - state localparams ST_INIT / ST_RUN.
  - Requester count constant NREQ = 2.
- Sub-module rr_arb2: 2-way round-robin grant logic. Inputs: req[1:0], last, en. Output: grant[1:0] (one-hot or zero). Purely combinational; the rr_last register stays in the top block.

Test Plan:
- Reset with INIT_EN=1, DEPTH=16, INIT_VAL=16'hA5A5 -> mem_wr=1 for exactly 16 cycles at addrs 0..15; init_done rises the next cycle; no req_ready during the sweep; a read of addr 7 afterwards returns 16'hA5A5.
- Requester 0 writes 16'h1234 to addr 3, then requester 1 reads addr 3 -> rsp_valid=1, rsp_id=1, rsp_rdata=16'h1234 one cycle after the read handshake.
- Both requesters hold reads valid for 6 cycles -> grants alternate 0,1,0,1,0,1; rsp_id follows the same pattern one cycle later; no cycle without a grant.
- Only requester 1 valid, 4 consecutive reads -> granted every cycle, 4 back-to-back responses; afterwards both valid -> requester 0 granted first.
- Assert rst for one cycle the cycle after a read handshake -> rsp_valid stays 0 that cycle; the init sweep restarts at addr 0.
- INIT_EN=0 -> init_done=1 and req_ready usable on the first cycle after reset release; a write is accepted on that cycle.
